// File: rtl/button_repeat_filter.sv
// button_repeat_filter: turns one raw push-button into a debounced level,
// a step pulse stream (press, then auto-repeat while held), and a release pulse.
// Signal chain: 2-flop synchroniser -> debounce filter -> auto-repeat FSM.
module button_repeat_filter #(
    parameter int    ClockPeriod_ns     = 20,
    parameter int    FilterPeriod_ns    = 1_000_000,
    parameter int    PauseInterval_ns   = 450_000_000,
    parameter int    RepeatsInterval_ns = 150_000_000,
    parameter string ActiveLow          = "Yes"
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Button,
    output logic Pressed,
    output logic Step,
    output logic Released
);
    // Tick counts derived from the nanosecond parameters.
    localparam int FT = FilterPeriod_ns / ClockPeriod_ns;
    localparam int PT = PauseInterval_ns / ClockPeriod_ns;
    localparam int RT = RepeatsInterval_ns / ClockPeriod_ns;

    // Counters only ever reach their terminal value minus one, so size for that.
    localparam int FW = (FT > 1) ? $clog2(FT) : 1;
    localparam int TW = (PT > 1) ? $clog2(PT) : 1;

    localparam logic [FW-1:0] F_LAST = FW'(FT - 1);
    localparam logic [TW-1:0] P_LAST = TW'(PT - 1);
    localparam logic [TW-1:0] R_LAST = TW'(RT - 1);

    // Raw level of a released button; the synchroniser resets to it.
    localparam logic ACT_LOW = (ActiveLow == "Yes");

    if (FT < 1 || RT < 1 || PT < RT) begin : g_param_check
        $error("button_repeat_filter: tick counts need FT>=1, RT>=1 and PT>=RT");
    end

    typedef enum logic [1:0] {IDLE, PAUSE, REPEAT} state_t;

    logic          sync1, sync2;
    logic          btn_now;
    logic [FW-1:0] flt_cnt;
    logic          differ, accept, accept_press, accept_release;
    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          step_nx, rel_nx;

    // Two-flop synchroniser; reset loads the released level so no edge appears on exit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= ACT_LOW;
            sync2 <= ACT_LOW;
        end else begin
            sync1 <= Button;
            sync2 <= sync1;
        end
    end

    // Normalise polarity: 1 = pressed.
    assign btn_now        = sync2 ^ ACT_LOW;
    assign differ         = btn_now ^ Pressed;
    assign accept         = differ && (flt_cnt == F_LAST);
    assign accept_press   = accept && !Pressed;
    assign accept_release = accept && Pressed;

    // Debounce: count consecutive disagreeing samples, flip the level after FT of them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flt_cnt <= '0;
            Pressed <= 1'b0;
        end else if (!differ) begin
            flt_cnt <= '0;
        end else if (accept) begin
            flt_cnt <= '0;
            Pressed <= ~Pressed;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // Auto-repeat next-state logic; a release always beats a timer expiry in the same cycle.
    always_comb begin
        state_nx = state;
        timer_nx = timer + 1'b1;
        step_nx  = 1'b0;
        rel_nx   = accept_release;
        unique case (state)
            IDLE: begin
                timer_nx = '0;
                if (accept_press) begin
                    step_nx  = 1'b1;
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (accept_release) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == P_LAST) begin
                    step_nx  = 1'b1;
                    state_nx = REPEAT;
                    timer_nx = '0;
                end
            end
            REPEAT: begin
                if (accept_release) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == R_LAST) begin
                    step_nx  = 1'b1;
                    timer_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // FSM state, timer and registered pulse outputs (aligned with the Pressed flip).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            timer    <= '0;
            Step     <= 1'b0;
            Released <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            Step     <= step_nx;
            Released <= rel_nx;
        end
    end

endmodule
